regfile_mp: RTL and testbench

Parametrised multi-port register file for the processor datapath, succeeding the fixed 32x32 two-read/one-write file. Adds:
- a second write port with defined priority;
- optional write-to-read bypass;
- an optional hardwired zero register;
- a per-register busy scoreboard, so issue logic can detect pending writebacks.

Reads are combinational. Writes, busy updates and conflict reporting are synchronous to `clk`.

---
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised 2R/2W register file with bypass, zero register and busy scoreboard
//
// Ports:
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   rd_addr_a/b -> rd_data_a/b      combinational read data
//                  rd_busy_a/b      busy bit of the read address
//   wr_en_0, wr_addr_0, wr_data_0   write port 0
//   wr_en_1, wr_addr_1, wr_data_1   write port 1 (wins over port 0 on the same address)
//   claim_en, claim_addr            marks a register busy from the next cycle
//   wr_conflict                     registered pulse: both write ports hit one address last cycle
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_b,
    input  logic              wr_en_0,
    input  logic [ADDR_W-1:0] wr_addr_0,
    input  logic [DATA_W-1:0] wr_data_0,
    input  logic              wr_en_1,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [DATA_W-1:0] wr_data_1,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              conflict_q, conflict_d;

    // Effective write/claim strobes: gated by reset and by the hardwired zero register.
    logic we0, we1, claim_eff;

    always_comb begin
        we0        = wr_en_0  && !rst && !(ZERO_REG && (wr_addr_0  == '0));
        we1        = wr_en_1  && !rst && !(ZERO_REG && (wr_addr_1  == '0));
        claim_eff  = claim_en && !rst && !(ZERO_REG && (claim_addr == '0));
        conflict_d = we0 && we1 && (wr_addr_0 == wr_addr_1);
    end

    // A claim beats a writeback to the same register: the new producer owns it.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (claim_eff && (claim_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((we0 && (wr_addr_0 == ADDR_W'(r))) ||
                         (we1 && (wr_addr_1 == ADDR_W'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (we0) mem_q[wr_addr_0] <= wr_data_0;
            // Port 1 assigned last so it wins when both target the same register.
            if (we1) mem_q[wr_addr_1] <= wr_data_1;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = conflict_q;

    // Read port A
    logic hit0_a, hit1_a;
    always_comb begin
        hit0_a    = we0 && (wr_addr_0 == rd_addr_a);
        hit1_a    = we1 && (wr_addr_1 == rd_addr_a);
        rd_data_a = mem_q[rd_addr_a];
        rd_busy_a = busy_q[rd_addr_a];
        if (ZERO_REG && (rd_addr_a == '0)) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end else if (BYPASS) begin
            if (hit1_a)      rd_data_a = wr_data_1;
            else if (hit0_a) rd_data_a = wr_data_0;
            // A same-cycle claim keeps the stored busy bit visible; claims are never forwarded.
            if ((hit0_a || hit1_a) && !(claim_eff && (claim_addr == rd_addr_a))) begin
                rd_busy_a = 1'b0;
            end
        end
    end

    // Read port B
    logic hit0_b, hit1_b;
    always_comb begin
        hit0_b    = we0 && (wr_addr_0 == rd_addr_b);
        hit1_b    = we1 && (wr_addr_1 == rd_addr_b);
        rd_data_b = mem_q[rd_addr_b];
        rd_busy_b = busy_q[rd_addr_b];
        if (ZERO_REG && (rd_addr_b == '0)) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end else if (BYPASS) begin
            if (hit1_b)      rd_data_b = wr_data_1;
            else if (hit0_b) rd_data_b = wr_data_0;
            if ((hit0_b || hit1_b) && !(claim_eff && (claim_addr == rd_addr_b))) begin
                rd_busy_b = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (bypass and non-bypass instances)
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic        wr_en_0, wr_en_1, claim_en;
    logic [4:0]  wr_addr_0, wr_addr_1, claim_addr;
    logic [31:0] wr_data_0, wr_data_1;

    logic [31:0] bp_data_a, bp_data_b, nb_data_a, nb_data_b;
    logic        bp_busy_a, bp_busy_b, nb_busy_a, nb_busy_b;
    logic        bp_conflict, nb_conflict;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_bp (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(bp_data_a), .rd_busy_a(bp_busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(bp_data_b), .rd_busy_b(bp_busy_b),
        .wr_en_0(wr_en_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
        .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .wr_conflict(bp_conflict)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(nb_data_a), .rd_busy_a(nb_busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(nb_data_b), .rd_busy_b(nb_busy_b),
        .wr_en_0(wr_en_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
        .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .wr_conflict(nb_conflict)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; wr_en_0 = 1'b0; wr_en_1 = 1'b0; claim_en = 1'b0;
        wr_addr_0 = '0; wr_addr_1 = '0; claim_addr = '0;
        wr_data_0 = '0; wr_data_1 = '0;
    endtask

    // Advance one edge, then let outputs settle before the caller samples.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        wr_en_0 = 1'b1; wr_addr_0 = a; wr_data_0 = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        wr_en_1 = 1'b1; wr_addr_1 = a; wr_data_1 = d;
    endtask

    initial begin
        idle();
        rd_addr_a = '0; rd_addr_b = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("reset_conflict_bp", {31'b0, bp_conflict}, 32'h0);
        check("reset_conflict_nb", {31'b0, nb_conflict}, 32'h0);

        // Preload some registers and claims, then reset with a write in flight.
        for (int i = 1; i < 32; i += 3) begin
            idle();
            wr0(5'(i), 32'h1000_0000 + i);
            wr1(5'(31 - i), 32'hA5A5_0000 + i);
            claim_en = 1'b1; claim_addr = 5'(i + 1);
            tick();
        end
        idle();
        wr0(5'd5, 32'h0000_0055);
        tick();
        idle();
        rst = 1'b1;
        wr0(5'd5, 32'h0000_0099);
        claim_en = 1'b1; claim_addr = 5'd6;
        rd_addr_a = 5'd5;
        #1;
        check("rst_no_bypass_data", bp_data_a, 32'h0000_0055);
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            check($sformatf("sweep_data_a_%0d", i), bp_data_a, 32'h0);
            check($sformatf("sweep_data_b_%0d", i), bp_data_b, 32'h0);
            check($sformatf("sweep_busy_a_%0d", i), {31'b0, bp_busy_a}, 32'h0);
            check($sformatf("sweep_busy_b_%0d", i), {31'b0, nb_busy_b}, 32'h0);
        end
        check("sweep_conflict", {31'b0, bp_conflict}, 32'h0);

        // Write priority and conflict pulse at reg 7.
        idle();
        wr0(5'd7, 32'h1111_1111);
        wr1(5'd7, 32'h2222_2222);
        rd_addr_a = 5'd7;
        #1;
        check("prio_bypass_bp", bp_data_a, 32'h2222_2222);
        check("prio_old_nb", nb_data_a, 32'h0);
        check("prio_conflict_same_cycle", {31'b0, bp_conflict}, 32'h0);
        tick();
        idle();
        #1;
        check("prio_data_bp", bp_data_a, 32'h2222_2222);
        check("prio_data_nb", nb_data_a, 32'h2222_2222);
        check("prio_conflict_bp", {31'b0, bp_conflict}, 32'h1);
        check("prio_conflict_nb", {31'b0, nb_conflict}, 32'h1);
        tick();
        check("prio_conflict_drop", {31'b0, bp_conflict}, 32'h0);

        // Different addresses on the two ports: both stored, no conflict.
        wr0(5'd8, 32'h0000_0808);
        wr1(5'd10, 32'h0000_1010);
        tick();
        idle();
        rd_addr_a = 5'd8; rd_addr_b = 5'd10;
        #1;
        check("dual_wr_a", nb_data_a, 32'h0000_0808);
        check("dual_wr_b", nb_data_b, 32'h0000_1010);
        check("dual_wr_conflict", {31'b0, bp_conflict}, 32'h0);

        // Back-to-back conflicts hold the flag high.
        wr0(5'd3, 32'h3);
        wr1(5'd3, 32'h33);
        tick();
        check("b2b_conflict_1", {31'b0, bp_conflict}, 32'h1);
        wr0(5'd3, 32'h4);
        wr1(5'd3, 32'h44);
        tick();
        idle();
        rd_addr_a = 5'd3;
        #1;
        check("b2b_conflict_2", {31'b0, bp_conflict}, 32'h1);
        check("b2b_data", nb_data_a, 32'h44);
        tick();
        check("b2b_conflict_end", {31'b0, bp_conflict}, 32'h0);

        // Both ports to the zero register: ignored, no conflict.
        wr0(5'd0, 32'h1111_1111);
        wr1(5'd0, 32'h2222_2222);
        rd_addr_a = 5'd0;
        #1;
        check("zero_bypass", bp_data_a, 32'h0);
        tick();
        idle();
        #1;
        check("zero_data", nb_data_a, 32'h0);
        check("zero_conflict", {31'b0, bp_conflict}, 32'h0);

        // Bypass of a single write.
        wr0(5'd5, 32'hDEAD_BEEF);
        rd_addr_a = 5'd5;
        #1;
        check("bypass_bp", bp_data_a, 32'hDEAD_BEEF);
        check("bypass_nb_old", nb_data_a, 32'h0);
        tick();
        idle();
        #1;
        check("bypass_nb_next", nb_data_a, 32'hDEAD_BEEF);

        // Scoreboard on reg 9.
        claim_en = 1'b1; claim_addr = 5'd9;
        rd_addr_b = 5'd9;
        #1;
        check("claim_t0", {31'b0, bp_busy_b}, 32'h0);
        tick();
        idle();
        #1;
        check("claim_t1", {31'b0, bp_busy_b}, 32'h1);
        tick();
        tick();
        check("claim_t2_nb", {31'b0, nb_busy_b}, 32'h1);
        wr1(5'd9, 32'h0000_0909);
        #1;
        check("wb_t3_bp", {31'b0, bp_busy_b}, 32'h0);
        check("wb_t3_nb", {31'b0, nb_busy_b}, 32'h1);
        tick();
        idle();
        #1;
        check("wb_t4_bp", {31'b0, bp_busy_b}, 32'h0);
        check("wb_t4_nb", {31'b0, nb_busy_b}, 32'h0);
        tick();
        check("wb_t5_bp", {31'b0, bp_busy_b}, 32'h0);

        // Claims to the zero register are ignored.
        claim_en = 1'b1; claim_addr = 5'd0;
        rd_addr_a = 5'd0;
        tick();
        idle();
        #1;
        check("zero_claim_busy", {31'b0, nb_busy_a}, 32'h0);

        // Claim and write to reg 12 in one cycle: data written, busy set.
        claim_en = 1'b1; claim_addr = 5'd12;
        wr0(5'd12, 32'hCAFE_0000);
        rd_addr_a = 5'd12;
        #1;
        check("collide_busy_same", {31'b0, bp_busy_a}, 32'h0);
        check("collide_data_same", bp_data_a, 32'hCAFE_0000);
        tick();
        idle();
        #1;
        check("collide_data", bp_data_a, 32'hCAFE_0000);
        check("collide_busy", {31'b0, bp_busy_a}, 32'h1);
        check("collide_busy_nb", {31'b0, nb_busy_a}, 32'h1);

        // Claim under reset is discarded, and reset clears the data.
        claim_en = 1'b1; claim_addr = 5'd12;
        rst = 1'b1;
        tick();
        idle();
        #1;
        check("rst_claim_busy", {31'b0, bp_busy_a}, 32'h0);
        check("rst_claim_data", bp_data_a, 32'h0);
        check("rst_claim_data_nb", nb_data_a, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
